// File: rtl/sy_ppl_fp_freelist.sv
// Free list of FP physical register indices for the rename stage.
// A circular array holds free indices between head and tail; cmt_head is the restore point on flush.
module sy_ppl_fp_freelist #(
  parameter int PHY_REG_NUM = 64,
  parameter int REG_WTH     = $clog2(PHY_REG_NUM)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               alloc_en_i,
  output logic               alloc_vld_o,
  output logic [REG_WTH-1:0] alloc_phy_o,
  output logic [REG_WTH-1:0] free_cnt_o,
  input  logic               commit_en_i,
  input  logic [REG_WTH-1:0] commit_old_phy_i
);

  localparam int PTR_WTH = REG_WTH + 1;

  logic [REG_WTH-1:0] fl [PHY_REG_NUM];
  logic [PTR_WTH-1:0] head;
  logic [PTR_WTH-1:0] cmt_head;
  logic [PTR_WTH-1:0] tail;

  logic [PTR_WTH-1:0] free_cnt;
  logic               full;
  logic               do_alloc;
  logic               do_release;
  logic [PTR_WTH-1:0] cmt_head_nxt;

  // The wrap bit makes tail - head distinguish a full list from an empty one.
  assign free_cnt     = tail - head;
  assign full         = (free_cnt == PTR_WTH'(PHY_REG_NUM - 1));
  assign alloc_vld_o  = (free_cnt != '0);
  assign alloc_phy_o  = fl[head[REG_WTH-1:0]];
  assign free_cnt_o   = free_cnt[REG_WTH-1:0];

  assign do_alloc     = alloc_en_i && alloc_vld_o && !flush_i;
  assign do_release   = commit_en_i && (commit_old_phy_i != '0) && !full;
  assign cmt_head_nxt = cmt_head + PTR_WTH'(commit_en_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head     <= '0;
      cmt_head <= '0;
      tail     <= PTR_WTH'(PHY_REG_NUM - 1);
      // NOTE: the array is reset on purpose: its initial contents ARE the free list (indices 1..N-1).
      for (int i = 0; i < PHY_REG_NUM; i++) begin
        fl[i] <= (i == PHY_REG_NUM - 1) ? '0 : REG_WTH'(i + 1);
      end
    end else begin
      cmt_head <= cmt_head_nxt;
      // A flush rewinds to the committed point, counting a commit made in the same cycle.
      head     <= flush_i ? cmt_head_nxt : head + PTR_WTH'(do_alloc);
      if (do_release) begin
        fl[tail[REG_WTH-1:0]] <= commit_old_phy_i;
        tail                  <= tail + PTR_WTH'(1);
      end
    end
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(commit_en_i && (commit_old_phy_i != '0) && full));

  a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
    commit_en_i |-> (cmt_head != head));

endmodule

// File: doc/sy_ppl_fp_freelist.md
# sy_ppl_fp_freelist

Free list for the floating-point physical register file. It sits directly upstream of the FP register alias table in the rename stage. It hands out free physical destination indices to renamed FP instructions and takes back superseded indices when the ROB commits. On pipeline flush it restores the speculative allocation pointer to the committed state, so physical registers allocated by squashed instructions become free again.

## Interface
- PHY_REG_NUM, 64, number of FP physical registers; power of two, > 32
- REG_WTH, $clog2(PHY_REG_NUM), physical index width
- clk_i  input  1  clock
- rst_i  input  1  reset; one clock, reset is synchronous and active-high
- flush_i  input  1  exception/mispredict flush; discard all uncommitted allocations
- alloc_en_i  input  1  rename consumes alloc_phy_o this cycle (FP instruction with rd)
- alloc_vld_o  output  1  free list non-empty; alloc_phy_o is valid
- alloc_phy_o  output  REG_WTH  next free physical index; goes to the RAT phy_rdst_idx input
- free_cnt_o  output  REG_WTH  number of free entries available for allocation
- commit_en_i  input  1  ROB commits one FP instruction that has an rd
- commit_old_phy_i  input  REG_WTH  previous mapping of the committed rd, to be released

## Operation
- Storage: circular array fl[PHY_REG_NUM] of REG_WTH entries.
- Pointers, each REG_WTH+1 bits with a wrap bit:
  - head: speculative allocation pointer
  - cmt_head: committed allocation pointer
  - tail: release pointer
- free_cnt = tail - head, modulo 2^(REG_WTH+1). Capacity is PHY_REG_NUM-1.
- Physical index 0 is the reset mapping of every architectural register. It is never allocated and never released.
- Reset state:
  - fl[i] = i+1 for i = 0..PHY_REG_NUM-2; fl[PHY_REG_NUM-1] = 0 (unused)
  - head = cmt_head = 0; tail = PHY_REG_NUM-1
  - alloc_vld_o = 1, alloc_phy_o = 1, free_cnt_o = PHY_REG_NUM-1
- Allocate:
  - Condition: alloc_en_i && alloc_vld_o && !flush_i
  - Action: head += 1
  - alloc_en_i while empty is ignored. Upstream must stall on !alloc_vld_o.
- Commit (commit_en_i): cmt_head += 1.
- Release:
  - Condition: commit_en_i && commit_old_phy_i != 0
  - Action: fl[tail] = commit_old_phy_i; tail += 1
  - Release with old index 0 advances cmt_head only.
- Flush (flush_i): head <= the next-cycle value of cmt_head, including a commit in the same cycle.
  - Allocation is suppressed.
  - A commit or release in the same cycle is still performed.
- Overflow: release when free_cnt == PHY_REG_NUM-1 is illegal. Drop the write and fire a simulation assertion.
- Underflow guard: cmt_head must never pass head. Simulation assertion.

## Timing
- alloc_vld_o, alloc_phy_o and free_cnt_o are combinational from registered state only, with no input-to-output paths.
- Allocation: the next index appears on alloc_phy_o the cycle after alloc_en_i.
- Release:
  - A released index becomes allocatable the cycle after commit_en_i.
  - There is no same-cycle bypass to an empty list: alloc_vld_o stays 0 in the release cycle.
- Simultaneous alloc and release in one cycle: both take effect, and free_cnt is unchanged.
- Flush: the restored head is visible the next cycle. Allocation resumes that cycle, from the entry at cmt_head.
- Reset mid-operation: all state returns to the reset values the next cycle, regardless of flush or commit inputs.
- Wrap-around: pointers wrap modulo PHY_REG_NUM for indexing. The wrap bit distinguishes full from empty.

## Test plan
- Reset, then 3 cycles of alloc_en_i=1:
  - alloc_phy_o = 1, 2, 3 in successive cycles, then 4.
  - free_cnt_o goes 63 → 60.
- Drain all 63 entries:
  - alloc_vld_o = 0 and free_cnt_o = 0.
  - Further alloc_en_i leaves the pointers unchanged.
  - Commit with old=5: the next cycle alloc_vld_o = 1 and alloc_phy_o = 5.
- Allocate 1, 2, 3; commit one instruction with old=0; assert flush_i:
  - The next cycle alloc_phy_o = 2 and free_cnt_o = 62.
- flush_i and commit_en_i (old=7) in the same cycle, after 4 allocations and 1 prior commit:
  - head restores to cmt_head = 2, so alloc_phy_o = 3.
  - 7 is appended at the tail; free_cnt_o = 62.
- Simultaneous alloc_en_i and commit (old=9) at free_cnt 10: free_cnt stays 10, and 9 is allocated after the existing entries.
- Run more than 200 random alloc/commit/flush cycles against a reference model:
  - No index is allocated twice while live.
  - Index 0 is never allocated.
  - Pointer wrap is correct.
  - Reset asserted mid-sequence restores alloc_phy_o = 1 and free_cnt_o = 63.
